// File: rtl/izhikevich_array.sv
// rtl/izhikevich_array.sv - round-robin Izhikevich neuron engine with internal v/u state file
// Define IZH_SATURATE_EN to clamp products and sums; otherwise results wrap modulo 2^WIDTH.
module izhikevich_array #(
   parameter int WIDTH     = 17,
   parameter int FRAC      = 8,
   parameter int N_NEURONS = 16,
   parameter int THRESH    = 30 << FRAC,
   parameter int V_INIT    = -(65 << FRAC),
   parameter int U_INIT    = -(13 << FRAC)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [WIDTH-1:0]      a,
   input  logic signed [WIDTH-1:0]      b,
   input  logic signed [WIDTH-1:0]      c,
   input  logic signed [WIDTH-1:0]      d,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [WIDTH-1:0]      in_current,
   output logic [$clog2(N_NEURONS)-1:0] in_idx,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(N_NEURONS)-1:0] out_idx,
   output logic signed [WIDTH-1:0]      out_v,
   output logic signed [WIDTH-1:0]      out_u,
   output logic                         out_fired,
   output logic                         out_last
);
   localparam int IDXW = $clog2(N_NEURONS);

   typedef logic signed [WIDTH-1:0]   word_t;
   typedef logic signed [WIDTH+1:0]   wide_t;
   typedef logic signed [2*WIDTH-1:0] dbl_t;
   typedef logic [IDXW-1:0]           idx_t;

   localparam word_t KCOEF    = WIDTH'((4 * (1 << FRAC) + 50) / 100);
   localparam word_t THR      = WIDTH'(THRESH);
   localparam word_t VINIT    = WIDTH'(V_INIT);
   localparam word_t UINIT    = WIDTH'(U_INIT);
   localparam wide_t C140     = (WIDTH+2)'(140 << FRAC);
   localparam idx_t  LAST_IDX = IDXW'(N_NEURONS - 1);

   if (N_NEURONS < 5) begin : g_n_check
      $error("izhikevich_array: N_NEURONS must be at least 5");
   end

`ifdef IZH_SATURATE_EN
   localparam dbl_t WMAX = dbl_t'(2 ** (WIDTH - 1) - 1);
   localparam dbl_t WMIN = dbl_t'(-(2 ** (WIDTH - 1)));
`endif

   function automatic word_t fit(input dbl_t x);
`ifdef IZH_SATURATE_EN
      if (x > WMAX) return WIDTH'(WMAX);
      if (x < WMIN) return WIDTH'(WMIN);
`endif
      return WIDTH'(x);
   endfunction

   function automatic wide_t ext(input word_t x);
      return (WIDTH+2)'(x);
   endfunction

   function automatic word_t rsum(input wide_t x);
      return fit((2*WIDTH)'(x));
   endfunction

   // Fixed-point multiply: full-width product, floor shift by FRAC, then reduce.
   function automatic word_t mul(input word_t x, input word_t y);
      dbl_t p;
      p = (2*WIDTH)'(x) * (2*WIDTH)'(y);
      return fit(p >>> FRAC);
   endfunction

   word_t v_mem_q [N_NEURONS];
   word_t u_mem_q [N_NEURONS];
   idx_t  in_idx_q, in_idx_d;

   logic  vld1_q;
   word_t v1_q, u1_q, i1_q, a1_q, c1_q, d1_q;
   word_t kv1_q, v5_1_q, bv1_q, kv1_d, v5_1_d, bv1_d;
   idx_t  idx1_q;

   logic  vld2_q;
   word_t v2_q, u2_q, i2_q, a2_q, c2_q, d2_q;
   word_t kvv2_q, v5_2_q, bmu2_q, kvv2_d, bmu2_d;
   idx_t  idx2_q;

   logic  vld3_q;
   word_t v3_q, u3_q, i3_q, c3_q, d3_q;
   word_t s3_q, abu3_q, s3_d, abu3_d;
   idx_t  idx3_q;

   logic  vld4_q;
   word_t c4_q, vn4_q, un4_q, us4_q, vn4_d, un4_d, us4_d;
   idx_t  idx4_q;

   logic  out_valid_q, out_fired_q, out_last_q;
   word_t out_v_q, out_u_q;
   idx_t  out_idx_q;

   logic  en, accept, fire;
   word_t rd_v, rd_u, wb_v, wb_u;

   always_comb begin
      en       = !out_valid_q || out_ready;
      accept   = in_valid && en;
      rd_v     = v_mem_q[in_idx_q];
      rd_u     = u_mem_q[in_idx_q];
      in_idx_d = in_idx_q;
      if (accept) begin
         in_idx_d = (in_idx_q == LAST_IDX) ? '0 : in_idx_q + IDXW'(1);
      end

      kv1_d  = mul(KCOEF, rd_v);
      v5_1_d = rsum((ext(rd_v) <<< 2) + ext(rd_v));
      bv1_d  = mul(b, rd_v);

      kvv2_d = mul(kv1_q, v1_q);
      bmu2_d = rsum(ext(bv1_q) - ext(u1_q));

      s3_d   = rsum(ext(kvv2_q) + ext(v5_2_q) + C140 - ext(u2_q));
      abu3_d = mul(a2_q, bmu2_q);

      vn4_d  = rsum(ext(s3_q) + ext(i3_q) + ext(v3_q));
      un4_d  = rsum(ext(u3_q) + ext(abu3_q));
      us4_d  = rsum(ext(u3_q) + ext(d3_q));

      fire   = (vn4_q >= THR);
      wb_v   = fire ? c4_q : vn4_q;
      wb_u   = fire ? us4_q : un4_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_idx_q    <= '0;
         vld1_q      <= 1'b0;
         vld2_q      <= 1'b0;
         vld3_q      <= 1'b0;
         vld4_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_fired_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= '0;
         out_v_q     <= '0;
         out_u_q     <= '0;
         for (int k = 0; k < N_NEURONS; k++) begin
            v_mem_q[k] <= VINIT;
            u_mem_q[k] <= UINIT;
         end
      end else if (en) begin
         in_idx_q <= in_idx_d;

         vld1_q <= in_valid;
         v1_q   <= rd_v;
         u1_q   <= rd_u;
         i1_q   <= in_current;
         a1_q   <= a;
         c1_q   <= c;
         d1_q   <= d;
         idx1_q <= in_idx_q;
         kv1_q  <= kv1_d;
         v5_1_q <= v5_1_d;
         bv1_q  <= bv1_d;

         vld2_q <= vld1_q;
         v2_q   <= v1_q;
         u2_q   <= u1_q;
         i2_q   <= i1_q;
         a2_q   <= a1_q;
         c2_q   <= c1_q;
         d2_q   <= d1_q;
         idx2_q <= idx1_q;
         kvv2_q <= kvv2_d;
         v5_2_q <= v5_1_q;
         bmu2_q <= bmu2_d;

         vld3_q <= vld2_q;
         v3_q   <= v2_q;
         u3_q   <= u2_q;
         i3_q   <= i2_q;
         c3_q   <= c2_q;
         d3_q   <= d2_q;
         idx3_q <= idx2_q;
         s3_q   <= s3_d;
         abu3_q <= abu3_d;

         vld4_q <= vld3_q;
         c4_q   <= c3_q;
         idx4_q <= idx3_q;
         vn4_q  <= vn4_d;
         un4_q  <= un4_d;
         us4_q  <= us4_d;

         // Output load and state write-back share one edge; N_NEURONS >= 5 keeps reads clear of it.
         out_valid_q <= vld4_q;
         if (vld4_q) begin
            out_idx_q        <= idx4_q;
            out_v_q          <= wb_v;
            out_u_q          <= wb_u;
            out_fired_q      <= fire;
            out_last_q       <= (idx4_q == LAST_IDX);
            v_mem_q[idx4_q]  <= wb_v;
            u_mem_q[idx4_q]  <= wb_u;
         end
      end
   end

   assign in_ready  = en;
   assign in_idx    = in_idx_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_v     = out_v_q;
   assign out_u     = out_u_q;
   assign out_fired = out_fired_q;
   assign out_last  = out_last_q;
endmodule

// File: tb/tb_izhikevich_array.sv
// tb/tb_izhikevich_array.sv - directed, table-driven bench for izhikevich_array
module tb_izhikevich_array;
   localparam int W = 17;
   localparam int N = 16;

   logic clk = 1'b0;
   logic rst;
   logic signed [W-1:0] a, b, c, d, in_current, out_v, out_u;
   logic in_valid, in_ready, out_valid, out_ready, out_fired, out_last;
   logic [3:0] in_idx, out_idx;

   int checks = 0;
   int errors = 0;

   izhikevich_array dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
      .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current), .in_idx(in_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_v(out_v), .out_u(out_u), .out_fired(out_fired), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cur;
      int cv;
      int idx;
      int v;
      int u;
      int fired;
   } vec_t;

   vec_t tbl [48];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Streams tbl[base +: nw]; optional 3-cycle out_ready stall starting at iteration stall_at.
   task automatic run_stream(input int base, input int nw, input int stall_at);
      int sent, got, first_acc, first_out, lasts, gaps, k;
      logic signed [W-1:0] hv, hu;
      logic [3:0] hidx, hin;
      logic hf;
      sent = 0; got = 0; first_acc = -1; first_out = -1; lasts = 0; gaps = 0;
      for (int it = 0; it < 200 && got < nw; it++) begin
         @(negedge clk);
         k = (sent < nw) ? base + sent : base;
         in_valid   = (sent < nw);
         in_current = W'(tbl[k].cur);
         c          = W'(tbl[k].cv);
         out_ready  = !(stall_at >= 0 && it >= stall_at && it < stall_at + 3);
         #1;
         if (stall_at >= 0 && it == stall_at) begin
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            hv = out_v; hu = out_u; hidx = out_idx; hin = in_idx; hf = out_fired;
         end
         if (stall_at >= 0 && it > stall_at && it < stall_at + 3) begin
            chk("stall_in_ready_hold", int'(in_ready), 0);
            chk("stall_out_valid_hold", int'(out_valid), 1);
            chk("stall_v_frozen", int'(out_v), int'(hv));
            chk("stall_u_frozen", int'(out_u), int'(hu));
            chk("stall_idx_frozen", int'(out_idx), int'(hidx));
            chk("stall_fired_frozen", int'(out_fired), int'(hf));
            chk("stall_in_idx_frozen", int'(in_idx), int'(hin));
         end
         if (out_valid && out_ready) begin
            if (first_out < 0) first_out = it;
            chk($sformatf("out_idx[%0d]", base + got), int'(out_idx), tbl[base + got].idx);
            chk($sformatf("out_v[%0d]", base + got), int'(out_v), tbl[base + got].v);
            chk($sformatf("out_u[%0d]", base + got), int'(out_u), tbl[base + got].u);
            chk($sformatf("out_fired[%0d]", base + got), int'(out_fired), tbl[base + got].fired);
            chk($sformatf("out_last[%0d]", base + got), int'(out_last),
                (tbl[base + got].idx == N - 1) ? 1 : 0);
            if (out_last) lasts++;
            got++;
         end else if (first_out >= 0 && !out_valid) begin
            gaps++;
         end
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = it;
            chk($sformatf("in_idx[%0d]", base + sent), int'(in_idx), tbl[base + sent].idx);
            sent++;
         end
      end
      in_valid = 1'b0;
      chk("stream_complete", got, nw);
      chk("first_latency", first_out - first_acc, 5);
      chk("bubbles", gaps, 0);
      chk("last_count", lasts, nw / N);
   endtask

   initial begin
      // Sweep 1 from reset state, sweep 2 from its write-back, then a post-reset sweep.
      for (int i = 0; i < 48; i++) begin
         tbl[i].cur   = 0;
         tbl[i].cv    = -16640;
         tbl[i].idx   = i % N;
         tbl[i].fired = 0;
         if (i < 16 || i >= 32) begin
            tbl[i].v = -18422; tbl[i].u = -3328;
         end else begin
            tbl[i].v = -19553; tbl[i].u = -3335;
         end
      end
      tbl[1].cur  = 51200; tbl[1].v  = -16640; tbl[1].u  = -1280; tbl[1].fired = 1;
      tbl[2].cur  = 51200; tbl[2].cv = 51200;
      tbl[2].v    = 51200; tbl[2].u  = -1280; tbl[2].fired = 1;
      tbl[17].v   = -20470; tbl[17].u = -1320;
      tbl[18].cv  = 51200;  tbl[18].v = -42112; tbl[18].u = -1056;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_current = '0;
      a = 17'sd5; b = 17'sd51; c = -17'sd16640; d = 17'sd2048;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_v", int'(out_v), 0);
      chk("rst_out_u", int'(out_u), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_fired", int'(out_fired), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_in_idx", int'(in_idx), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      rst = 1'b0;

      run_stream(0, 32, 6);

      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_current = '0; c = -17'sd16640; out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("in_idx_before_rst", int'(in_idx), 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_idx", int'(in_idx), 0);
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("midrst_no_output", int'(out_valid), 0);
      end

      run_stream(32, 16, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/izhikevich_array.md
# izhikevich_array

Time-multiplexed, parametrised Izhikevich neuron engine: one 4-stage fixed-point datapath evaluates N_NEURONS neurons in round-robin order, with per-neuron v/u state held internally. Input currents arrive on a valid/ready stream and updated states leave on a valid/ready stream. The block sits between the synaptic current accumulator and the spike router of the graph accelerator, and supersedes the single-neuron, externally-stated pipeline.

## Interface
- WIDTH, 17: signed two's-complement word width of all datapath values.
- FRAC, 8: fractional bits (Q(WIDTH-FRAC).FRAC).
- N_NEURONS, 16: neurons served; must be ≥ 5 (elaboration error otherwise).
- THRESH, 30<<FRAC: spike threshold, compared as v_next ≥ THRESH (signed).
- V_INIT, -65<<FRAC / U_INIT, -13<<FRAC: per-neuron state after reset.
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- a, b, c, d  in  WIDTH each  shared model parameters, sampled with each accepted input
- in_valid  in  1  current word valid
- in_ready  out  1  current word accepted when in_valid && in_ready
- in_current  in  WIDTH  input current I for neuron in_idx
- in_idx  out  clog2(N_NEURONS)  neuron index the next accepted word applies to
- out_valid  in→out  1  (output) result valid
- out_ready  in  1  downstream accepts result
- out_idx  out  clog2(N_NEURONS)  neuron index of result
- out_v, out_u  out  WIDTH  updated state
- out_fired  out  1  spike flag
- out_last  out  1  result is neuron N_NEURONS-1 (end of sweep)

## Operation
- in_idx counter: starts at 0, increments on each accepted input, wraps N_NEURONS-1 → 0.
- Stage 1 (acceptance cycle): read v,u of in_idx from internal register file; register v,u,I,a,b,c,d,idx, plus K·v and 5·v (K = 10 for FRAC=8; generally round(0.04·2^FRAC)) and b·v.
- Stage 2: K·v·v; b·v − u.
- Stage 3: s = K·v² + 5v + 140 − u; a·(b·v − u).
- Stage 4: v_next = s + I + v; u_next = u + a·(b·v − u); u_spk = u + d (old u).
- Fire: if v_next ≥ THRESH, out_v = c, out_u = u_spk, out_fired = 1; else out_v = v_next, out_u = u_next, out_fired = 0.
- Write-back: out_v/out_u are written to the state file at idx in the same edge that loads the output register. N_NEURONS ≥ 5 guarantees no read-before-write hazard.
- Products: full 2·WIDTH signed product, arithmetic shift right by FRAC (floor), then reduced to WIDTH per Configuration. Adds are computed at WIDTH+2 bits, then reduced the same way.

## Timing
- Pipeline enable en = !out_valid || out_ready; all stages advance only when en=1. in_ready = en.
- Latency: a word accepted at edge n appears with out_valid=1 after edge n+4, provided there are no stalls. Throughput is 1 neuron per cycle.
- Stall: when out_valid && !out_ready, all stage registers, outputs and in_idx hold, and in_ready = 0.
- Bubbles: stage valid bits propagate without in_valid; out_valid drops when a bubble reaches stage 4 and en=1.
- Reset (rst=1 at an edge): all stage valid bits 0; out_valid, out_fired, out_last 0; out_idx, out_v, out_u 0; in_idx 0; every neuron v = V_INIT, u = U_INIT. Reset mid-sweep discards in-flight results with no write-back.
- Results with out_fired=1 are held stable until accepted.

## Configuration
- IZH_SATURATE_EN defined: every product and sum that exceeds the WIDTH range clamps to the maximum positive or maximum negative value; threshold is compared on the clamped value.
- IZH_SATURATE_EN undefined: results wrap (low WIDTH bits kept, two's complement), matching a modular reference model bit-exactly.

## Test plan
- Reset, a=5, b=51, c=-65<<8, d=8<<8, I=0 for neuron 0, out_ready=1 → after 4 cycles out_idx=0, out_v = -18422 LSB (-71.9609375), out_u = -3328 LSB, out_fired=0.
- Same, I = 200<<8 → out_fired=1, out_v = -16640 LSB (c), out_u = -1280 LSB (-13+8), and the next sweep for neuron 0 reads v=-65.
- Continuous in_valid over 2·N_NEURONS words → in_idx wraps 15→0, out_last pulses on idx 15 exactly twice, one result per cycle, and sweep-2 values use the sweep-1 write-back.
- out_ready low for 3 cycles mid-stream → in_ready=0, outputs frozen, no word lost or duplicated, and ordering is preserved.
- c = 200<<8 on spike, then the next sweep with v=200: with IZH_SATURATE_EN → out_fired=1; without it → out_v/out_fired equal the wrapping model.
- rst asserted with 3 words in flight → out_valid=0 next cycle, in_idx=0, and all states read back V_INIT/U_INIT on the following sweep.
